// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 VGA timing constants and sync bundle type
package vga_timing_pkg;

  localparam int unsigned POS_W      = 10;

  localparam int unsigned H_ACTIVE   = 640;
  localparam int unsigned H_FP       = 16;
  localparam int unsigned H_SYNC     = 96;
  localparam int unsigned H_BP       = 48;
  localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE   = 480;
  localparam int unsigned V_FP       = 10;
  localparam int unsigned V_SYNC     = 2;
  localparam int unsigned V_BP       = 33;
  localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC - 1;

  // Matches the downstream pixel-state plus colour pipeline latency.
  localparam int unsigned SYNC_DELAY = 2;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank;
  } sync_bits_t;

endpackage

// File: rtl/sync_delay_line.sv
// rtl/sync_delay_line.sv - clock-enabled shift register with reset load value
module sync_delay_line #(
  parameter int unsigned          WIDTH     = 1,
  parameter int unsigned          DEPTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      // Input is already registered upstream, so zero depth is a plain wire.
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst_n, en};
      assign dout        = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < int'(DEPTH); i++) begin
            stage_q[i] <= RESET_VAL;
          end
        end else if (en) begin
          stage_q[0] <= din;
          for (int i = 1; i < int'(DEPTH); i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA position counters, decode and delayed sync/blank generation
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
  parameter int unsigned H_FP       = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP       = vga_timing_pkg::H_BP,
  parameter int unsigned V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
  parameter int unsigned V_FP       = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC     = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP       = vga_timing_pkg::V_BP,
  parameter int unsigned SYNC_DELAY = vga_timing_pkg::SYNC_DELAY
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_En,
  output logic [9:0] o_PixelPos_X,
  output logic [9:0] o_PixelPos_Y,
  output logic       o_Active,
  output logic       o_hSync,
  output logic       o_vSync,
  output logic       o_Blank,
  output logic       o_LineStart,
  output logic       o_FrameStart
);
  import vga_timing_pkg::*;

  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] x_q, y_q, x_next, y_next;
  logic       active_q, line_q, frame_q, active_next;
  sync_bits_t raw_q, raw_next, dly_out;

  // Everything is decoded from the next position so it registers alongside it.
  always_comb begin
    x_next = x_q + 10'd1;
    y_next = y_q;
    if (x_q >= H_LAST) begin
      x_next = '0;
      y_next = (y_q >= V_LAST) ? 10'd0 : y_q + 10'd1;
    end
    active_next    = (x_next < H_VIS) && (y_next < V_VIS);
    raw_next.hsync = !((x_next >= H_SS) && (x_next <= H_SE));
    raw_next.vsync = !((y_next >= V_SS) && (y_next <= V_SE));
    raw_next.blank = !active_next;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      x_q      <= '0;
      y_q      <= '0;
      active_q <= 1'b1;
      line_q   <= 1'b1;
      frame_q  <= 1'b1;
      raw_q    <= '{hsync: 1'b1, vsync: 1'b1, blank: 1'b0};
    end else if (i_En) begin
      x_q      <= x_next;
      y_q      <= y_next;
      active_q <= active_next;
      line_q   <= (x_next == 10'd0);
      frame_q  <= (x_next == 10'd0) && (y_next == 10'd0);
      raw_q    <= raw_next;
    end else begin
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
    end
  end

  sync_delay_line #(
    .WIDTH     ($bits(sync_bits_t)),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL (3'b111)
  ) u_sync_delay (
    .clk   (i_Clk),
    .rst_n (i_Rst_n),
    .en    (i_En),
    .din   (raw_q),
    .dout  (dly_out)
  );

  assign o_PixelPos_X = x_q;
  assign o_PixelPos_Y = y_q;
  assign o_Active     = active_q;
  assign o_LineStart  = line_q;
  assign o_FrameStart = frame_q;
  assign o_hSync      = dly_out.hsync;
  assign o_vSync      = dly_out.vsync;
  assign o_Blank      = dly_out.blank;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench: full-size and shrunken-timing instances vs arithmetic model
module tb_vga_sync_gen;

  localparam int A_HA = 640, A_HFP = 16, A_HS = 96, A_HBP = 48;
  localparam int A_VA = 480, A_VFP = 10, A_VS = 2,  A_VBP = 33, A_D = 2;
  localparam int B_HA = 16,  B_HFP = 2,  B_HS = 4,  B_HBP = 3;
  localparam int B_VA = 6,   B_VFP = 2,  B_VS = 2,  B_VBP = 2,  B_D = 0;
  localparam int N_CYC = 12000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  logic [9:0] a_x, a_y, b_x, b_y;
  logic a_act, a_hs, a_vs, a_bl, a_ls, a_fs;
  logic b_act, b_hs, b_vs, b_bl, b_ls, b_fs;
  logic [25:0] got_a, got_b;

  assign got_a = {a_x, a_y, a_act, a_hs, a_vs, a_bl, a_ls, a_fs};
  assign got_b = {b_x, b_y, b_act, b_hs, b_vs, b_bl, b_ls, b_fs};

  vga_sync_gen dut_a (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_En(en),
    .o_PixelPos_X(a_x), .o_PixelPos_Y(a_y), .o_Active(a_act),
    .o_hSync(a_hs), .o_vSync(a_vs), .o_Blank(a_bl),
    .o_LineStart(a_ls), .o_FrameStart(a_fs)
  );

  vga_sync_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
    .SYNC_DELAY(B_D)
  ) dut_b (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_En(en),
    .o_PixelPos_X(b_x), .o_PixelPos_Y(b_y), .o_Active(b_act),
    .o_hSync(b_hs), .o_vSync(b_vs), .o_Blank(b_bl),
    .o_LineStart(b_ls), .o_FrameStart(b_fs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [25:0] a;
    logic [25:0] b;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // k = enabled advances since reset; pok = no disabled edge since the last advance.
  function automatic logic [25:0] model(int k, bit pok, int ha, int hfp, int hsw, int hbp,
                                        int va, int vfp, int vsw, int vbp, int d);
    int ht, vt, p, x, y, pd, xd, yd;
    logic act, hs, vs, bl;
    ht  = ha + hfp + hsw + hbp;
    vt  = va + vfp + vsw + vbp;
    p   = k % (ht * vt);
    x   = p % ht;
    y   = p / ht;
    act = (x < ha) && (y < va);
    if (k < d) begin
      hs = 1'b1; vs = 1'b1; bl = 1'b1;
    end else begin
      pd = (k - d) % (ht * vt);
      xd = pd % ht;
      yd = pd / ht;
      hs = !(xd >= ha + hfp && xd < ha + hfp + hsw);
      vs = !(yd >= va + vfp && yd < va + vfp + vsw);
      bl = !(xd < ha && yd < va);
    end
    return {10'(x), 10'(y), act, hs, vs, bl, pok && (x == 0), pok && (x == 0) && (y == 0)};
  endfunction

  task automatic check(input string name, input int cyc, input logic [25:0] got, input logic [25:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s cycle %0d: got {x,y,act,hs,vs,bl,ls,fs}=%0d,%0d,%b required %0d,%0d,%b",
               name, cyc, got[25:16], got[15:6], got[5:0], req[25:16], req[15:6], req[5:0]);
    end
  endtask

  // Monitor: compare the DUT state after each edge with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("dut_a_640x480", e.cyc, got_a, e.a);
        check("dut_b_small", e.cyc, got_b, e.b);
      end
    end
  end

  // Stimulus: decide inputs for the next edge and queue the state it should produce.
  initial begin
    exp_t e;
    int   k;
    bit   pok;
    int   rst_hold;
    k = 0;
    pok = 1'b1;
    rst_hold = 0;
    for (int c = 0; c < N_CYC; c++) begin
      @(negedge clk);
      if (c < 3) begin
        rst_n = 1'b0;
        en    = 1'($urandom_range(0, 1));
      end else begin
        if (rst_hold > 0) rst_hold--;
        else if (c == 6000) rst_hold = 2;
        else if (c > 7000 && $urandom_range(0, 999) == 0) rst_hold = $urandom_range(1, 3);
        rst_n = (rst_hold == 0);
        if (c < 5000)      en = 1'b1;
        else if (c < 7000) en = 1'((c % 2) == 0);
        else               en = ($urandom_range(0, 3) != 0);
      end
      if (!rst_n) begin
        k = 0; pok = 1'b1;
      end else if (en) begin
        k++; pok = 1'b1;
      end else begin
        pok = 1'b0;
      end
      e.a   = model(k, pok, A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP, A_D);
      e.b   = model(k, pok, B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, B_D);
      e.cyc = c;
      sb.push_back(e);
    end
    @(posedge clk);
    #4;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameters H_FP 16, H_SYNC 96, H_BP 48 (line total 800); V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33 (frame total 525).
REQ-003 Parameter SYNC_DELAY, 2, cycles by which sync/blank lag position, matching the downstream GALAGA pixel-state plus colour latency.
REQ-004 i_Clk  input  1  single clock, 25 MHz pixel rate, rising edge.
REQ-005 i_Rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_En  input  1  pixel enable; counters advance only when high.
REQ-007 o_PixelPos_X  output  10  horizontal counter, 0..799.
REQ-008 o_PixelPos_Y  output  10  vertical counter, 0..524.
REQ-009 o_Active  output  1  high when X<640 and Y<480, aligned with position.
REQ-010 o_hSync  output  1  horizontal sync, active-low, delayed SYNC_DELAY.
REQ-011 o_vSync  output  1  vertical sync, active-low, delayed SYNC_DELAY.
REQ-012 o_Blank  output  1  high outside visible area, delayed SYNC_DELAY.
REQ-013 o_LineStart  output  1  one-cycle pulse when X=0, aligned with position.
REQ-014 o_FrameStart  output  1  one-cycle pulse when X=0 and Y=0, aligned with position.

Function
REQ-015 All outputs SHALL be registered; position, o_Active, o_LineStart and o_FrameStart SHALL describe the same pixel in the same cycle.
REQ-016 On each rising edge with i_En=1, X SHALL increment; at X=799 X SHALL wrap to 0 and Y SHALL increment; at X=799,Y=524 both SHALL wrap to 0 in the same cycle.
REQ-017 With i_En=0, counters, o_Active and the delay line SHALL hold; o_LineStart and o_FrameStart SHALL be 0.
REQ-018 Raw hSync SHALL be low for X in 656..751 inclusive; raw vSync SHALL be low for Y in 490..491 inclusive.
REQ-019 Raw blank SHALL equal NOT o_Active.
REQ-020 Raw hSync, vSync and blank SHALL pass through a SYNC_DELAY-stage shift register that advances only on i_En=1; SYNC_DELAY=0 SHALL give combinational-free, same-cycle alignment (registered from counters).
REQ-021 o_LineStart SHALL be high for the first enabled cycle of each line and fall on the next enabled advance; o_FrameStart likewise once per frame.
REQ-022 Counter arithmetic SHALL be 10-bit unsigned; values above 799/524 SHALL be unreachable.

Reset
REQ-023 On i_Rst_n low, X=0, Y=0, o_Active=1, o_LineStart=1, o_FrameStart=1 asynchronously.
REQ-024 On reset all delay-line stages SHALL load hSync=1, vSync=1, blank=1, so o_hSync=1, o_vSync=1, o_Blank=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame; after release the first enabled edge SHALL advance to X=1, Y=0.

Structure
REQ-026 Timing constants (H_*, V_*, totals, sync start/end) SHALL live in shared package vga_timing_pkg, also used by GALAGA and its testbench.
REQ-027 The delay line SHALL be sub-module sync_delay_line (parameters WIDTH, DEPTH, RESET_VAL, clock enable).
REQ-028 Horizontal/vertical counters and decode SHALL be in vga_sync_gen itself.

Verification
REQ-029 Reset release, i_En=1 constant -> o_FrameStart high at cycle 0 and every 420000 cycles; o_LineStart every 800 cycles.
REQ-030 Line scan -> o_hSync low exactly 96 cycles, first low cycle when o_PixelPos_X=658 (656+SYNC_DELAY); o_Blank rises when X=642.
REQ-031 Frame scan -> o_vSync low for 1600 cycles starting at Y=490, X=2; o_Active high for 307200 cycles per frame.
REQ-032 i_En toggled 1 cycle on / 1 off -> line period 1600 clocks, pulse widths doubled, no skipped or duplicated position.
REQ-033 Reset asserted at X=300,Y=200 -> immediately X=0, Y=0, o_hSync=o_vSync=o_Blank=1; after release sequence matches REQ-029.
REQ-034 Wrap at X=799,Y=524 -> next enabled edge gives X=0,Y=0 with o_FrameStart=1 and no Y=525 observed.
